// File: rtl/data_mem_responder.sv
// Responder end of the GPU data-memory port: an on-chip word array that serves one read or
// write request at a time. It adds a programmable latency, alternates between reads and writes, and counts the traffic.
module data_mem_responder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_valid,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_valid,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ready,
  output logic                  err_out_of_range,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
);

  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0]      RD_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0]      WR_LOAD  = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    accept, accept_read;
  logic                    op_read;
  logic                    last_read;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [ADDR_WIDTH:0]     diff;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    resp;

  // The extra top bit catches addresses below the window without wrapping.
  assign diff     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign in_range = !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < DEPTH_A);
  assign idx      = diff[IDX_W-1:0];
  assign resp     = (state == RESP);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept      = 1'b0;
    accept_read = 1'b0;
    case (state)
      IDLE: begin
        if (read_valid || write_valid) begin
          accept      = 1'b1;
          // When both ports request, serve the kind of access that was not accepted last time.
          accept_read = read_valid && !(write_valid && last_read);
          if (accept_read) begin
            cnt_next   = RD_LOAD;
            state_next = (READ_LATENCY == 1) ? RESP : RD_WAIT;
          end else begin
            cnt_next   = WR_LOAD;
            state_next = (WRITE_LATENCY == 1) ? RESP : WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_next = cnt - CNT_ONE;
        if (!read_valid)        state_next = IDLE;
        else if (cnt == CNT_ONE) state_next = RESP;
      end
      WR_WAIT: begin
        cnt_next = cnt - CNT_ONE;
        if (!write_valid)       state_next = IDLE;
        else if (cnt == CNT_ONE) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      op_read          <= 1'b0;
      last_read        <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      err_out_of_range <= 1'b0;
      read_count       <= '0;
      write_count      <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        op_read   <= accept_read;
        last_read <= accept_read;
        addr_q    <= accept_read ? read_address : write_address;
        wdata_q   <= write_data;
      end
      if (resp) begin
        if (op_read) read_count  <= read_count + 32'd1;
        else         write_count <= write_count + 32'd1;
        if (!in_range) err_out_of_range <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset, so its contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (resp && !op_read && in_range) mem[idx] <= wdata_q;
  end

  // Reads sample the array during the response cycle, so any write that has already committed is visible.
  assign read_ready  = resp && op_read;
  assign write_ready = resp && !op_read;
  assign read_data   = read_ready ? (in_range ? mem[idx] : OOR_DATA) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder. Expected responses come from a word-array
// model and are checked by an independent monitor against the response cycle and the data.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          RLAT  = 1;
  localparam int          WLAT  = 3;
  localparam logic [31:0] BASE  = 32'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_valid, write_valid;
  logic [31:0] read_address, write_address, write_data;
  logic        read_ready, write_ready, err_out_of_range;
  logic [31:0] read_data, read_count, write_count;

  data_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .READ_LATENCY(RLAT), .WRITE_LATENCY(WLAT)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .write_ready(write_ready), .err_out_of_range(err_out_of_range),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the storage window as a plain array plus the bookkeeping visible at the ports.
  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  bit          last_rd_m = 1'b0;
  bit          err_m = 1'b0;
  int unsigned rc_m = 0, wc_m = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH);
  endfunction

  function automatic void model_op(input bit is_read, input logic [31:0] a,
                                   input logic [31:0] d, input int unsigned at);
    exp_t e;
    e.is_read = is_read;
    e.at      = at;
    if (!in_win(a)) err_m = 1'b1;
    if (is_read) begin
      e.data = in_win(a) ? mem_m[int'(a - BASE)] : 32'hDEAD_BEEF;
      rc_m++;
    end else begin
      if (in_win(a)) mem_m[int'(a - BASE)] = d;
      e.data = d;
      wc_m++;
    end
    last_rd_m = is_read;
    sb.push_back(e);
  endfunction

  // Monitor: every ready pulse must match the oldest expected response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (read_ready || write_ready) begin
        check("ready_overlap", {31'd0, read_ready & write_ready}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_ready", {30'd0, read_ready, write_ready}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_op", {31'd0, read_ready}, {31'd0, mon_e.is_read});
          check("resp_cycle", cyc, mon_e.at);
          if (mon_e.is_read) check("read_data", read_data, mon_e.data);
        end
      end else begin
        check("idle_read_data", read_data, 32'd0);
      end
    end
  end

  task automatic wait_ready(input bit is_read);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_read ? read_ready : write_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check(is_read ? "rd_ready_seen" : "wr_ready_seen", {31'd0, seen}, 32'd1);
  endtask

  // All driver tasks start and end 1 time unit after a rising clock edge.
  task automatic single(input bit is_read, input logic [31:0] a, input logic [31:0] d);
    if (is_read) begin
      read_valid = 1'b1; read_address = a;
    end else begin
      write_valid = 1'b1; write_address = a; write_data = d;
    end
    model_op(is_read, a, d, cyc + (is_read ? RLAT : WLAT));
    wait_ready(is_read);
    @(posedge clk); #1;
    if (is_read) read_valid = 1'b0;
    else         write_valid = 1'b0;
  endtask

  task automatic dual(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
    bit first_rd;
    int l1, l2;
    read_valid = 1'b1; read_address = ra;
    write_valid = 1'b1; write_address = wa; write_data = wd;
    first_rd = !last_rd_m;
    l1 = first_rd ? RLAT : WLAT;
    l2 = first_rd ? WLAT : RLAT;
    model_op(first_rd, first_rd ? ra : wa, wd, cyc + l1);
    model_op(!first_rd, first_rd ? wa : ra, wd, cyc + l1 + l2 + 1);
    wait_ready(first_rd);
    @(posedge clk); #1;
    if (first_rd) read_valid = 1'b0;
    else          write_valid = 1'b0;
    wait_ready(!first_rd);
    @(posedge clk); #1;
    read_valid = 1'b0; write_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_read_count"}, read_count, rc_m);
    check({tag, "_write_count"}, write_count, wc_m);
    check({tag, "_err"}, {31'd0, err_out_of_range}, {31'd0, err_m});
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 19) == 0) begin
      case ($urandom_range(0, 2))
        0:       return BASE - 32'd1;
        1:       return BASE + DEPTH;
        default: return $urandom | 32'h8000_0000;
      endcase
    end
    return BASE + $urandom_range(0, DEPTH - 1);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, a2;
    reset = 1'b1;
    read_valid = 1'b0; write_valid = 1'b0;
    read_address = '0; write_address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_ready", {31'd0, read_ready}, 32'd0);
    check("rst_write_ready", {31'd0, write_ready}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check_state("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Write then read the same word.
    single(1'b0, BASE + 32'd5, 32'h1234_5678);
    single(1'b1, BASE + 32'd5, '0);
    check_state("raw");

    for (int i = 0; i < DEPTH; i++) single(1'b0, BASE + i, $urandom);
    check_state("preload");

    // Reset while a write waits: no pulse, no store, counters cleared.
    write_valid = 1'b1; write_address = BASE + 32'd7; write_data = 32'hCAFE_0007;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    write_valid = 1'b0;
    rc_m = 0; wc_m = 0; err_m = 1'b0; last_rd_m = 1'b0;
    #1;
    check("midrst_write_ready", {31'd0, write_ready}, 32'd0);
    check_state("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests from reset: the read goes first and sees the pre-write contents.
    dual(BASE + 32'd7, BASE + 32'd7, 32'hA5A5_0007);
    single(1'b1, BASE + 32'd7, '0);
    check_state("dual");

    // Window edges and sticky error flag.
    single(1'b1, BASE + DEPTH - 1, '0);
    single(1'b1, BASE + DEPTH, '0);
    check_state("oor_hi");
    single(1'b1, BASE, '0);
    single(1'b1, BASE - 32'd1, '0);
    single(1'b0, BASE + DEPTH, 32'h0BAD_F00D);
    single(1'b1, BASE + 32'd1, '0);
    check_state("oor");

    // A write withdrawn one cycle after accept leaves no trace, but it still counts as the last accepted access.
    single(1'b1, BASE + 32'd9, '0);
    write_valid = 1'b1; write_address = BASE + 32'd9; write_data = 32'hBAD0_0009;
    @(posedge clk); #1;
    write_valid = 1'b0;
    last_rd_m = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    dual(BASE + 32'd9, BASE + 32'd10, 32'h0000_0010);
    check_state("abort");

    // Back-to-back single-cycle reads: one pulse every two cycles.
    for (int i = 0; i < 100; i++) single(1'b1, BASE + ((i * 7) % DEPTH), '0);
    check_state("b2b");

    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      a = rand_addr();
      if (r < 4) begin
        single(1'b1, a, '0);
      end else if (r < 8) begin
        single(1'b0, a, $urandom);
      end else begin
        a2 = ($urandom_range(0, 3) == 0) ? a : rand_addr();
        dual(a, a2, $urandom);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check_state("final");
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
